// File: rtl/mem2d_pkg.sv
// Shared types for the 2D strided memory walker: operating modes and FSM state encoding.
package mem2d_pkg;

    typedef enum logic {
        MODE_FILL = 1'b0,
        MODE_COPY = 1'b1
    } mode_e;

    localparam logic MEM2D_MODE_FILL = 1'b0;
    localparam logic MEM2D_MODE_COPY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_RD     = 3'd2,
        ST_RWAIT  = 3'd3,
        ST_WR     = 3'd4,
        ST_NEXT   = 3'd5,
        ST_ROWEND = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

endpackage

// File: rtl/mem2d_addr_gen.sv
// Row/column counters, region geometry latched at go, and source/destination address generation.
module mem2d_addr_gen
    import mem2d_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int DIM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MEM_AW-1:0]   src_base,
    input  logic [MEM_AW-1:0]   dst_base,
    input  logic [DIM_BITS-1:0] src_stride,
    input  logic [DIM_BITS-1:0] dst_stride,
    input  logic [DIM_BITS-1:0] rows,
    input  logic [DIM_BITS-1:0] cols,
    input  logic                col_step,
    input  logic                row_step,
    output logic [MEM_AW-1:0]   src_addr,
    output logic [MEM_AW-1:0]   dst_addr,
    output logic [DIM_BITS-1:0] fill_sum,
    output logic                col_more,
    output logic                row_more,
    output logic                region_empty
);

    logic [DIM_BITS-1:0] i_q, i_d;
    logic [DIM_BITS-1:0] j_q, j_d;
    logic [DIM_BITS-1:0] rows_q, rows_d;
    logic [DIM_BITS-1:0] cols_q, cols_d;
    logic [DIM_BITS-1:0] src_stride_q, src_stride_d;
    logic [DIM_BITS-1:0] dst_stride_q, dst_stride_d;
    logic [MEM_AW-1:0]   src_row_q, src_row_d;
    logic [MEM_AW-1:0]   dst_row_q, dst_row_d;

    logic [DIM_BITS-1:0] i_inc;
    logic [DIM_BITS-1:0] j_inc;

    assign i_inc = i_q + DIM_BITS'(1);
    assign j_inc = j_q + DIM_BITS'(1);

    // Row base addresses accumulate one stride per row instead of multiplying stride by i.
    always_comb begin
        i_d          = i_q;
        j_d          = j_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        src_row_d    = src_row_q;
        dst_row_d    = dst_row_q;
        if (load) begin
            i_d          = '0;
            j_d          = '0;
            rows_d       = rows;
            cols_d       = cols;
            src_stride_d = src_stride;
            dst_stride_d = dst_stride;
            src_row_d    = src_base;
            dst_row_d    = dst_base;
        end else if (row_step) begin
            i_d       = i_inc;
            j_d       = '0;
            src_row_d = src_row_q + MEM_AW'(src_stride_q);
            dst_row_d = dst_row_q + MEM_AW'(dst_stride_q);
        end else if (col_step) begin
            j_d = j_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q          <= '0;
            j_q          <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            src_row_q    <= '0;
            dst_row_q    <= '0;
        end else begin
            i_q          <= i_d;
            j_q          <= j_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            src_row_q    <= src_row_d;
            dst_row_q    <= dst_row_d;
        end
    end

    // End tests compare the incremented index with != so full-range dimensions never overflow.
    assign src_addr     = src_row_q + MEM_AW'(j_q);
    assign dst_addr     = dst_row_q + MEM_AW'(j_q);
    assign fill_sum     = i_q + j_q + DIM_BITS'(1);
    assign col_more     = (j_inc != cols_q);
    assign row_more     = (i_inc != rows_q);
    assign region_empty = (rows_q == '0) || (cols_q == '0);

endmodule

// File: rtl/mem2d_walker.sv
// 2D strided fill/copy engine: FSM, single-outstanding memory handshake and data path.
// Define MEM2D_CSUM_EN to add the csum port holding the XOR of all written words.
module mem2d_walker
    import mem2d_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DIM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                mode,
    input  logic [MEM_AW-1:0]   src_base,
    input  logic [MEM_AW-1:0]   dst_base,
    input  logic [DIM_BITS-1:0] src_stride,
    input  logic [DIM_BITS-1:0] dst_stride,
    input  logic [DIM_BITS-1:0] rows,
    input  logic [DIM_BITS-1:0] cols,
    output logic                busy,
    output logic                ret,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata
`ifdef MEM2D_CSUM_EN
    ,
    output logic [MEM_DW-1:0]   csum
`endif
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [MEM_DW-1:0]   rdata_q, rdata_d;

    logic                load;
    logic                col_step;
    logic                row_step;
    logic [MEM_AW-1:0]   src_addr;
    logic [MEM_AW-1:0]   dst_addr;
    logic [DIM_BITS-1:0] fill_sum;
    logic [DIM_BITS-1:0] fill_inv;
    logic                col_more;
    logic                row_more;
    logic                region_empty;
    logic [MEM_DW-1:0]   wr_data;
    state_e              first_access;

    mem2d_addr_gen #(
        .MEM_AW   (MEM_AW),
        .DIM_BITS (DIM_BITS)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .src_stride   (src_stride),
        .dst_stride   (dst_stride),
        .rows         (rows),
        .cols         (cols),
        .col_step     (col_step),
        .row_step     (row_step),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .fill_sum     (fill_sum),
        .col_more     (col_more),
        .row_more     (row_more),
        .region_empty (region_empty)
    );

    assign fill_inv     = ~fill_sum;
    assign wr_data      = (mode_q == MODE_COPY) ? rdata_q : MEM_DW'(fill_inv);
    assign first_access = (mode_q == MODE_COPY) ? ST_RD : ST_WR;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rdata_d  = rdata_q;
        load     = 1'b0;
        col_step = 1'b0;
        row_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    load    = 1'b1;
                    mode_d  = (mode == MEM2D_MODE_COPY) ? MODE_COPY : MODE_FILL;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                state_d = region_empty ? ST_DONE : first_access;
            end
            ST_RD: begin
                if (mem_gnt) begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (mem_rdata_vld) begin
                    rdata_d = mem_rdata;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (mem_gnt) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                col_step = 1'b1;
                state_d  = col_more ? first_access : ST_ROWEND;
            end
            // Request stays low here for one cycle so the arbiter sees a bubble between rows.
            ST_ROWEND: begin
                row_step = 1'b1;
                state_d  = row_more ? first_access : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FILL;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields decode purely from registered state, so they hold steady while a grant is pending.
    always_comb begin
        busy      = 1'b0;
        ret       = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_DONE: begin
                ret = 1'b1;
            end
            ST_RD: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = src_addr;
            end
            ST_WR: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_addr;
                mem_wdata = wr_data;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

`ifdef MEM2D_CSUM_EN
    logic [MEM_DW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && go) begin
            csum_d = '0;
        end else if (state_q == ST_WR && mem_gnt) begin
            csum_d = csum_q ^ wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem2d_walker.sv
// Scoreboard bench for mem2d_walker: expected accesses queued per walk, checked on each grant.
// Checks the csum port too when MEM2D_CSUM_EN is defined.
module tb_mem2d_walker;

    localparam int MEM_AW   = 16;
    localparam int MEM_DW   = 32;
    localparam int DIM_BITS = 16;

    logic        clk;
    logic        rst;
    logic        go;
    logic        mode;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic [15:0] src_stride;
    logic [15:0] dst_stride;
    logic [15:0] rows;
    logic [15:0] cols;
    logic        busy;
    logic        ret;
    logic        mem_req;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rdata_vld;
    logic [31:0] mem_rdata;
`ifdef MEM2D_CSUM_EN
    logic [31:0] csum;
`endif

    mem2d_walker #(
        .MEM_AW   (MEM_AW),
        .MEM_DW   (MEM_DW),
        .DIM_BITS (DIM_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .mode          (mode),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .src_stride    (src_stride),
        .dst_stride    (dst_stride),
        .rows          (rows),
        .cols          (cols),
        .busy          (busy),
        .ret           (ret),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rdata_vld (mem_rdata_vld),
        .mem_rdata     (mem_rdata)
`ifdef MEM2D_CSUM_EN
        ,
        .csum          (csum)
`endif
    );

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    txn_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle_cnt = 0;
    int          go_cnt = 0;
    bit          sb_on = 1'b1;
    bit          stall_en = 1'b0;
    bit          spur_en = 1'b0;
    int          vld_delay = 1;
    logic [31:0] exp_csum;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle_cnt);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // Memory/arbiter model: random stalls, delayed read data, optional stray gnt/vld pulses.
    initial begin : responder
        bit          req_seen;
        bit          rd_out;
        int          stall_left;
        int          vld_cnt;
        logic [31:0] rd_word;
        logic [15:0] held_addr;
        logic [31:0] held_data;
        logic        held_write;
        txn_t        t;
        req_seen      = 1'b0;
        rd_out        = 1'b0;
        stall_left    = 0;
        vld_cnt       = 0;
        rd_word       = '0;
        held_addr     = '0;
        held_data     = '0;
        held_write    = 1'b0;
        mem_gnt       = 1'b0;
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mem_rdata_vld = 1'b0;
            if (vld_cnt > 0) begin
                vld_cnt--;
                if (vld_cnt == 0) begin
                    mem_rdata_vld = 1'b1;
                    mem_rdata     = rd_word;
                    rd_out        = 1'b0;
                end
            end
            if (!mem_rdata_vld && spur_en && !rd_out) begin
                mem_rdata_vld = 1'($urandom_range(0, 1));
                mem_rdata     = 32'($urandom);
            end
            if (mem_req) begin
                if (!req_seen) begin
                    req_seen   = 1'b1;
                    stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
                    held_addr  = mem_addr;
                    held_data  = mem_wdata;
                    held_write = mem_write;
                end else if (sb_on) begin
                    checkOutput("hold_addr", mem_addr, held_addr);
                    checkOutput("hold_wdata", mem_wdata, held_data);
                    checkOutput("hold_write", mem_write, held_write);
                end
                if (stall_left == 0) begin
                    mem_gnt  = 1'b1;
                    req_seen = 1'b0;
                    if (sb_on) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("txn_extra", 1, 0);
                        end else begin
                            t = exp_q.pop_front();
                            checkOutput("txn_write", mem_write, t.write);
                            checkOutput("txn_addr", mem_addr, t.addr);
                            if (t.write) checkOutput("txn_data", mem_wdata, t.data);
                            if (t.cyc >= 0) checkOutput("txn_cycle", cycle_cnt - go_cnt, t.cyc);
                        end
                    end
                    if (!mem_write) begin
                        rd_word = src_word(mem_addr);
                        vld_cnt = vld_delay;
                        rd_out  = 1'b1;
                    end
                end else begin
                    mem_gnt = 1'b0;
                    stall_left--;
                end
            end else begin
                req_seen = 1'b0;
                mem_gnt  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic md, input logic [15:0] sb, input logic [15:0] db,
                                 input logic [15:0] ss, input logic [15:0] ds,
                                 input logic [15:0] r, input logic [15:0] c,
                                 input bit stalls, input int vdel, input bit spur, input int exp_lat);
        txn_t        t;
        logic [15:0] sa;
        logic [15:0] s;
        int          lat;
        int          budget;
        bit          done;
        stall_en  = stalls;
        vld_delay = vdel;
        spur_en   = spur;
        exp_csum  = '0;
        exp_q.delete();
        for (int i = 0; i < int'(r); i++) begin
            for (int j = 0; j < int'(c); j++) begin
                sa = 16'(int'(sb) + int'(ss) * i + j);
                if (md) begin
                    t.write = 1'b0;
                    t.addr  = sa;
                    t.data  = '0;
                    t.cyc   = -1;
                    exp_q.push_back(t);
                end
                s       = 16'(i + j + 1);
                t.write = 1'b1;
                t.addr  = 16'(int'(db) + int'(ds) * i + j);
                t.data  = md ? src_word(sa) : {16'h0000, ~s};
                t.cyc   = (!md && !stalls) ? (2 + i * (2 * int'(c) + 1) + 2 * j) : -1;
                exp_csum = exp_csum ^ t.data;
                exp_q.push_back(t);
            end
        end
        budget = 100 + int'(r) * int'(c) * 40;
        @(negedge clk);
        go         = 1'b1;
        mode       = md;
        src_base   = sb;
        dst_base   = db;
        src_stride = ss;
        dst_stride = ds;
        rows       = r;
        cols       = c;
        go_cnt     = cycle_cnt;
        @(negedge clk);
        go         = 1'b0;
        mode       = ~md;
        src_base   = 16'($urandom);
        dst_base   = 16'($urandom);
        src_stride = 16'($urandom);
        dst_stride = 16'($urandom);
        rows       = 16'($urandom_range(1, 9));
        cols       = 16'($urandom_range(1, 9));
        checkOutput("busy_after_go", busy, 1);
        lat  = 1;
        done = 1'b0;
        while (!done && lat < budget) begin
            if (ret) begin
                done = 1'b1;
            end else begin
                go = (lat == 3 && r != 0 && c != 0);
                @(negedge clk);
                lat++;
            end
        end
        go = 1'b0;
        if (!done) begin
            checkOutput("ret_timeout", 0, 1);
        end else begin
            if (exp_lat >= 0) checkOutput("ret_latency", lat, exp_lat);
            checkOutput("busy_at_ret", busy, 0);
`ifdef MEM2D_CSUM_EN
            checkOutput("csum_at_ret", csum, exp_csum);
`endif
            @(negedge clk);
            checkOutput("ret_pulse", ret, 0);
        end
        checkOutput("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        spur_en  = 1'b0;
        stall_en = 1'b0;
    endtask

    initial begin : main
        bit saw_ret;
        rst        = 1'b1;
        go         = 1'b0;
        mode       = 1'b0;
        src_base   = '0;
        dst_base   = '0;
        src_stride = '0;
        dst_stride = '0;
        rows       = '0;
        cols       = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ret", ret, 0);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_write", mem_write, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0004, 16'd2, 16'd3, 1'b0, 1, 1'b0, 16);
        applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0004, 16'd0, 16'd3, 1'b0, 1, 1'b0, 2);
        applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0004, 16'd5, 16'd0, 1'b0, 1, 1'b0, 2);
        applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0004, 16'hFFFF, 16'd0, 1'b0, 1, 1'b0, 2);
        applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0004, 16'd2, 16'd3, 1'b1, 1, 1'b0, -1);
        applyStimulus(1'b1, 16'h0010, 16'h0040, 16'h0008, 16'h0002, 16'd2, 16'd2, 1'b0, 3, 1'b0, 28);
        applyStimulus(1'b1, 16'hFFF0, 16'h0300, 16'h0009, 16'h0005, 16'd3, 16'd3, 1'b1, 1, 1'b1, -1);
        applyStimulus(1'b0, 16'h0000, 16'hFFFE, 16'h0000, 16'h8000, 16'd2, 16'd3, 1'b0, 1, 1'b0, 16);

        sb_on = 1'b0;
        @(negedge clk);
        go         = 1'b1;
        mode       = 1'b0;
        dst_base   = 16'h0200;
        dst_stride = 16'h0010;
        rows       = 16'd3;
        cols       = 16'd4;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_req_before", mem_req, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ret", ret, 0);
        checkOutput("abort_req", mem_req, 0);
        checkOutput("abort_write", mem_write, 0);
        checkOutput("abort_addr", mem_addr, 0);
        checkOutput("abort_wdata", mem_wdata, 0);
        saw_ret = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ret) saw_ret = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ret || mem_req) saw_ret = 1'b1;
        end
        checkOutput("abort_no_ret", saw_ret, 0);
        sb_on = 1'b1;

        applyStimulus(1'b0, 16'h0000, 16'h0020, 16'h0000, 16'h0001, 16'd1, 16'd4, 1'b0, 1, 1'b0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
